// File: rtl/rs_param_station.sv
// rs_param_station: reservation station that snoops NUM_FWD forward buses; RS_AGE_ORDER_EN selects oldest-first issue.
// Latency: allocate-to-issue and wakeup-to-issue are 1 cycle minimum; outputs are combinational from registered state.
// Backpressure: in_ready drops when full; out_ready low holds all entries (the presented entry may change).
module rs_param_station #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 6,
    parameter int OP_W    = 4,
    parameter int NUM_FWD = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic [NUM_FWD*(1+TAG_W+DATA_W)-1:0]      fwd_bus,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [OP_W-1:0]                          in_op,
    input  logic [TAG_W-1:0]                         in_rob,
    input  logic                                     in_wait_a,
    input  logic                                     in_wait_b,
    input  logic [TAG_W-1:0]                         in_tag_a,
    input  logic [TAG_W-1:0]                         in_tag_b,
    input  logic [DATA_W-1:0]                        in_val_a,
    input  logic [DATA_W-1:0]                        in_val_b,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OP_W-1:0]                          out_op,
    output logic [TAG_W-1:0]                         out_rob,
    output logic [DATA_W-1:0]                        out_val_a,
    output logic [DATA_W-1:0]                        out_val_b,
    output logic [$clog2(DEPTH+1)-1:0]               count,
    output logic                                     full,
    output logic                                     empty
);
    localparam int FW = 1 + TAG_W + DATA_W;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [IW-1:0] idx_t;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rob;
        logic              waitA;
        logic              waitB;
        logic [TAG_W-1:0]  tagA;
        logic [TAG_W-1:0]  tagB;
        logic [DATA_W-1:0] valA;
        logic [DATA_W-1:0] valB;
    } entry_t;

    entry_t           ent [DEPTH];
    entry_t           newEnt;
    logic [DATA_W:0]  snA [DEPTH];
    logic [DATA_W:0]  snB [DEPTH];
    logic [DATA_W:0]  inSnA;
    logic [DATA_W:0]  inSnB;
    logic [DEPTH-1:0] busyVec;
    logic [DEPTH-1:0] readyVec;
    idx_t             allocIdx;
    idx_t             selIdx;
    logic             doAlloc;
    logic             doIssue;

    // Returns {hit, value}; scanning downward lets the lowest-index matching bus win.
    function automatic logic [DATA_W:0] snoop(input logic [NUM_FWD*FW-1:0] bus,
                                              input logic [TAG_W-1:0]      tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (bus[k*FW + FW - 1] && (bus[k*FW + DATA_W +: TAG_W] == tag))
                r = {1'b1, bus[k*FW +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busyVec[i]  = ent[i].busy;
            readyVec[i] = ent[i].busy && !ent[i].waitA && !ent[i].waitB;
            snA[i]      = snoop(fwd_bus, ent[i].tagA);
            snB[i]      = snoop(fwd_bus, ent[i].tagB);
        end
    end

    always_comb begin
        allocIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busyVec[i])
                allocIdx = idx_t'(i);
        end
    end

    // Operands whose producer is broadcasting this cycle are captured on the way in.
    always_comb begin
        inSnA        = snoop(fwd_bus, in_tag_a);
        inSnB        = snoop(fwd_bus, in_tag_b);
        newEnt.busy  = 1'b1;
        newEnt.op    = in_op;
        newEnt.rob   = in_rob;
        newEnt.tagA  = in_tag_a;
        newEnt.tagB  = in_tag_b;
        newEnt.waitA = in_wait_a && !inSnA[DATA_W];
        newEnt.waitB = in_wait_b && !inSnB[DATA_W];
        newEnt.valA  = (in_wait_a && inSnA[DATA_W]) ? inSnA[DATA_W-1:0] : in_val_a;
        newEnt.valB  = (in_wait_b && inSnB[DATA_W]) ? inSnB[DATA_W-1:0] : in_val_b;
    end

`ifdef RS_AGE_ORDER_EN
    // older[i][j] set means entry i was allocated before entry j.
    logic [DEPTH-1:0] older [DEPTH];

    always_comb begin
        logic blocked;
        blocked = 1'b0;
        selIdx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (readyVec[j] && older[j][i])
                    blocked = 1'b1;
            end
            if (readyVec[i] && !blocked)
                selIdx = idx_t'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            older <= '{default: '0};
        end else if (doAlloc) begin
            for (int j = 0; j < DEPTH; j++) begin
                older[j][allocIdx] <= busyVec[j];
                older[allocIdx][j] <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        selIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (readyVec[i])
                selIdx = idx_t'(i);
        end
    end
`endif

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = |readyVec;
    assign doAlloc   = in_valid && in_ready && !flush;
    assign doIssue   = out_valid && out_ready && !flush;

    assign out_op    = ent[selIdx].op;
    assign out_rob   = ent[selIdx].rob;
    assign out_val_a = ent[selIdx].valA;
    assign out_val_b = ent[selIdx].valB;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    ent[i].busy <= 1'b0;
                end else if (doAlloc && (allocIdx == idx_t'(i))) begin
                    ent[i] <= newEnt;
                end else begin
                    if (doIssue && (selIdx == idx_t'(i)))
                        ent[i].busy <= 1'b0;
                    if (ent[i].busy && ent[i].waitA && snA[i][DATA_W]) begin
                        ent[i].waitA <= 1'b0;
                        ent[i].valA  <= snA[i][DATA_W-1:0];
                    end
                    if (ent[i].busy && ent[i].waitB && snB[i][DATA_W]) begin
                        ent[i].waitB <= 1'b0;
                        ent[i].valB  <= snB[i][DATA_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            count <= '0;
        else
            count <= count + CW'(doAlloc) - CW'(doIssue);
    end

endmodule

// File: tb/tb_rs_param_station.sv
// Directed bench for rs_param_station: vector table for single-entry flows, hand sequences for fill, flush and issue order.
module tb_rs_param_station;
    localparam int DEPTH = 8, DATA_W = 16, TAG_W = 6, OP_W = 4, NUM_FWD = 4;
    localparam int FW = 1 + TAG_W + DATA_W;

    logic clk, reset, flush;
    logic [NUM_FWD*FW-1:0] fwd_bus;
    logic in_valid, in_ready, in_wait_a, in_wait_b, out_valid, out_ready, full, empty;
    logic [OP_W-1:0] in_op, out_op;
    logic [TAG_W-1:0] in_rob, in_tag_a, in_tag_b, out_rob;
    logic [DATA_W-1:0] in_val_a, in_val_b, out_val_a, out_val_b;
    logic [3:0] count;

    int nVec = 0;
    int nErr = 0;

    rs_param_station #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_FWD(NUM_FWD)) dut (
        .clk(clk), .reset(reset), .flush(flush), .fwd_bus(fwd_bus),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rob(in_rob),
        .in_wait_a(in_wait_a), .in_wait_b(in_wait_b), .in_tag_a(in_tag_a), .in_tag_b(in_tag_b),
        .in_val_a(in_val_a), .in_val_b(in_val_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rob(out_rob),
        .out_val_a(out_val_a), .out_val_b(out_val_b),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [5:0] rob; logic wa; logic [5:0] ta; logic [15:0] va;
        logic wb; logic [5:0] tb; logic [15:0] vb;
        logic f0v; logic [5:0] f0t; logic [15:0] f0d;
        logic f2v; logic [5:0] f2t; logic [15:0] f2d;
        logic ordy;
        logic eov; logic [5:0] erob; logic [15:0] ea; logic [15:0] eb; logic [3:0] ecnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int iv, rob, wa, ta, va, wb, tb, vb,
                                input int f0v, f0t, f0d, f2v, f2t, f2d, ordy,
                                input int eov, erob, ea, eb, ecnt);
        vec_t v;
        v.iv = 1'(iv); v.rob = 6'(rob); v.wa = 1'(wa); v.ta = 6'(ta); v.va = 16'(va);
        v.wb = 1'(wb); v.tb = 6'(tb); v.vb = 16'(vb);
        v.f0v = 1'(f0v); v.f0t = 6'(f0t); v.f0d = 16'(f0d);
        v.f2v = 1'(f2v); v.f2t = 6'(f2t); v.f2d = 16'(f2d);
        v.ordy = 1'(ordy);
        v.eov = 1'(eov); v.erob = 6'(erob); v.ea = 16'(ea); v.eb = 16'(eb); v.ecnt = 4'(ecnt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected full/empty/in_ready follow from the expected occupancy.
    task automatic chkState(input string nm, input logic eov, input logic [5:0] erob, input int ecnt);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(eov));
        if (eov) begin
            chk({nm, ".out_rob"}, 32'(out_rob), 32'(erob));
            chk({nm, ".out_op"}, 32'(out_op), 32'(erob[3:0]));
        end
        chk({nm, ".count"}, 32'(count), 32'(ecnt));
        chk({nm, ".full"}, 32'(full), 32'(ecnt == DEPTH));
        chk({nm, ".empty"}, 32'(empty), 32'(ecnt == 0));
        chk({nm, ".in_ready"}, 32'(in_ready), 32'(ecnt != DEPTH));
    endtask

    task automatic setFwd(input int k, input logic v, input logic [5:0] t, input logic [15:0] d);
        fwd_bus[k*FW +: FW] = {v, t, d};
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; fwd_bus = '0;
        in_op = '0; in_rob = '0; in_wait_a = 1'b0; in_wait_b = 1'b0;
        in_tag_a = '0; in_tag_b = '0; in_val_a = '0; in_val_b = '0;
    endtask

    task automatic dispatch(input int rob, wa, ta, va, wb, tb, vb);
        in_valid = 1'b1; in_rob = 6'(rob); in_op = 4'(rob);
        in_wait_a = 1'(wa); in_tag_a = 6'(ta); in_val_a = 16'(va);
        in_wait_b = 1'(wb); in_tag_b = 6'(tb); in_val_b = 16'(vb);
    endtask

    initial begin
        vec_t v;
        int order [7];

        // iv rob wa ta va  wb tb vb  f0v f0t f0d  f2v f2t f2d  ordy  eov erob ea eb cnt
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 5, 0, 0, 'h0011,  0, 0, 'h0022,  0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1, 5, 'h0011, 'h0022, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 7, 1, 9, 0,       0, 0, 'h0077,  0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 9, 'hBEEF,  1, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1, 7, 'hBEEF, 'h0077, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 10, 1, 12, 0,     0, 0, 1,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 12, 'hAAAA, 1, 12, 'h5555, 1, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1, 10, 'hAAAA, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 11, 0, 0, 3,      1, 4, 0,       0, 0, 0,       0, 4, 'hDEAD,  1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 4, 'h9999,  0, 0, 0,       1, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 4, 'h4444,  0, 0, 0,       1, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1, 11, 3, 'h4444, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 20, 0, 0, 'h0020, 1, 4, 0,       1, 4, 'h1234,  0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1, 20, 'h0020, 'h1234, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 21, 1, 30, 0,     1, 31, 0,      0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       1, 31, 'hB0B0, 1, 30, 'hA0A0, 1, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 1, 21, 'hA0A0, 'hB0B0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,       0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0, 0, 0, 0, 0));

        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            idle();
            if (v.iv) dispatch(v.rob, v.wa, v.ta, v.va, v.wb, v.tb, v.vb);
            setFwd(0, v.f0v, v.f0t, v.f0d);
            setFwd(2, v.f2v, v.f2t, v.f2d);
            out_ready = v.ordy;
            #1;
            chkState($sformatf("vec%0d", i), v.eov, v.erob, int'(v.ecnt));
            if (v.eov) begin
                chk($sformatf("vec%0d.val_a", i), 32'(out_val_a), 32'(v.ea));
                chk($sformatf("vec%0d.val_b", i), 32'(out_val_b), 32'(v.eb));
            end
            @(negedge clk);
        end

        // Fill to DEPTH with the FU stalled, then overlap issue and dispatch.
        idle();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dispatch(32 + i, 0, 0, i, 0, 0, 100 + i);
            #1;
            chk($sformatf("fill%0d.count", i), 32'(count), 32'(i));
            @(negedge clk);
        end
        dispatch(50, 0, 0, 0, 0, 0, 0);
        #1;
        chkState("full_extra", 1'b1, 6'd32, DEPTH);
        @(negedge clk);
        dispatch(51, 0, 0, 'h51, 0, 0, 'h51);
        out_ready = 1'b1;
        #1;
        chkState("full_issue", 1'b1, 6'd32, DEPTH);
        @(negedge clk);
        #1;
        chkState("refill", 1'b1, 6'd33, DEPTH - 1);
        @(negedge clk);
        idle();
`ifdef RS_AGE_ORDER_EN
        order = '{34, 35, 36, 37, 38, 39, 51};
`else
        order = '{51, 34, 35, 36, 37, 38, 39};
`endif
        for (int i = 0; i < 7; i++) begin
            #1;
            chkState($sformatf("drain%0d", i), 1'b1, 6'(order[i]), DEPTH - 1 - i);
            @(negedge clk);
        end
        #1;
        chkState("drained", 1'b0, 6'd0, 0);
        @(negedge clk);

        // Flush with three busy entries while dispatch and issue are requested.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dispatch(40 + i, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        dispatch(60, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chkState("flush_pre", 1'b1, 6'd40, 3);
        @(negedge clk);
        idle();
        #1;
        chkState("flush_post", 1'b0, 6'd0, 0);
        @(negedge clk);
        #1;
        chkState("flush_post2", 1'b0, 6'd0, 0);
        @(negedge clk);

        // Issue order after a slot is freed and reused.
        out_ready = 1'b1;
        dispatch(1, 1, 1, 0, 0, 0, 1);
        @(negedge clk);
        dispatch(2, 1, 2, 0, 0, 0, 2);
        @(negedge clk);
        idle();
        setFwd(0, 1'b1, 6'd1, 16'h0101);
        #1;
        chkState("age_wake1", 1'b0, 6'd0, 2);
        @(negedge clk);
        idle();
        #1;
        chkState("age_issue1", 1'b1, 6'd1, 2);
        chk("age_issue1.val_a", 32'(out_val_a), 32'h0101);
        @(negedge clk);
        dispatch(3, 1, 3, 0, 0, 0, 3);
        #1;
        chkState("age_alloc3", 1'b0, 6'd0, 1);
        @(negedge clk);
        idle();
        setFwd(0, 1'b1, 6'd2, 16'h0202);
        setFwd(2, 1'b1, 6'd3, 16'h0303);
        #1;
        chkState("age_wake23", 1'b0, 6'd0, 2);
        @(negedge clk);
        idle();
        #1;
`ifdef RS_AGE_ORDER_EN
        chkState("age_first", 1'b1, 6'd2, 2);
        chk("age_first.val_a", 32'(out_val_a), 32'h0202);
`else
        chkState("age_first", 1'b1, 6'd3, 2);
        chk("age_first.val_a", 32'(out_val_a), 32'h0303);
`endif
        @(negedge clk);
        #1;
`ifdef RS_AGE_ORDER_EN
        chkState("age_second", 1'b1, 6'd3, 1);
`else
        chkState("age_second", 1'b1, 6'd2, 1);
`endif
        @(negedge clk);
        #1;
        chkState("age_done", 1'b0, 6'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/rs_param_station.md
Name: rs_param_station

Overview:
- Parametrised successor to the 5-entry reservation station.
- Holds decoded ops that wait on operands and snoops NUM_FWD result-forward buses for tag matches.
- Issues one ready op per cycle to a functional unit through a valid/ready handshake, then frees the slot.
- Sits between rename/dispatch and one execution unit. Adds: slot free-on-issue, back-pressure, flush, capture-at-allocate, occupancy reporting.

Parameters:
- DEPTH, 8, number of entries (2..32)
- DATA_W, 16, operand value width
- TAG_W, 6, ROB tag width (also used as the operand-producer tag)
- OP_W, 4, opcode width
- NUM_FWD, 4, number of forward buses

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all entries (mispredict)
- fwd_bus  in  NUM_FWD*(1+TAG_W+DATA_W)  packed forward buses; bus k = {valid, tag, value}; bus 0 in the LSBs
- in_valid  in  1  dispatch request
- in_ready  out  1  station can accept (not full)
- in_op  in  OP_W  opcode
- in_rob  in  TAG_W  destination ROB tag
- in_wait_a / in_wait_b  in  1 each  operand still pending
- in_tag_a / in_tag_b  in  TAG_W each  producer tag of the operand
- in_val_a / in_val_b  in  DATA_W each  operand value, valid when wait=0
- out_valid  out  1  a ready entry is presented
- out_ready  in  1  FU accepts
- out_op  out  OP_W  opcode of the presented entry
- out_rob  out  TAG_W  ROB tag of the presented entry
- out_val_a / out_val_b  out  DATA_W each  operand values of the presented entry
- count  out  $clog2(DEPTH+1)  occupied entries
- full / empty  out  1 each  count==DEPTH / count==0

Behaviour:
- Reset, taking effect on the next edge: all entries invalid, count=0, empty=1, full=0, in_ready=1, out_valid=0. Output data values are don't-care while out_valid=0.
- Entry state: busy, op, rob, wait_a/b, tag_a/b, val_a/b. An entry is ready when busy && !wait_a && !wait_b.
- Allocate:
  - Happens when in_valid && in_ready. Writes the lowest-index free slot.
  - in_ready = !full, computed from state at the start of the cycle. A slot freed by an issue in the same cycle is not reusable until the next cycle.
- Capture-at-allocate: if an incoming operand has wait=1 and its tag matches a valid forward bus in the same cycle, the entry is written with wait=0 and the forwarded value.
- Wakeup: each busy entry compares each waiting operand against every valid forward bus every cycle.
  - On a match: clear wait and latch the value at the edge.
  - If several buses match the same operand, the lowest-index bus wins.
  - Operands A and B resolve independently, in the same cycle if both match.
- Issue:
  - out_valid is combinational from registered state. The entry selected is either the lowest-index ready entry, or the oldest when the optional feature is enabled.
  - A newly allocated entry, or one woken this cycle, is never presented before the next cycle. Minimum allocate-to-issue latency is 1 cycle.
  - On out_valid && out_ready the selected entry's busy bit clears at the edge.
  - While out_ready=0 the presented outputs are not required to stay stable: a higher-priority entry that becomes ready may replace the one presented.
- count: next = count + alloc - issue. Simultaneous allocate and issue leaves it unchanged. Never exceeds DEPTH and never underflows.
- flush: highest priority below reset. All busy bits clear at the edge, and allocate and issue in that cycle are ignored. The FU must treat any handshake in a flush cycle as void. out_valid=0 in the following cycle.
- Forward buses with valid=0 are ignored whatever their tag. Free slots never match.

Optional Feature:
- Macro RS_AGE_ORDER_EN.
- Defined: a DEPTH x DEPTH age matrix is kept.
  - On allocate, the new entry is marked younger than every busy entry.
  - Issue selects the oldest ready entry.
- Undefined: no age state; issue selects the lowest-index ready entry.
- Ports and all other behaviour are identical in both builds.

Test Plan:
- Reset then dispatch op=3, rob=5, both operands resolved, A=0x0011, B=0x0022, out_ready=1 -> next cycle out_valid=1 with out_rob=5, A=0x0011, B=0x0022; one cycle later count=0, empty=1.
- Dispatch rob=7 with wait_a=1, tag_a=9. fwd bus2 = {1, 9, 0xBEEF} two cycles later -> out_valid rises the cycle after the forward, with out_val_a=0xBEEF. Also drive the same tag on bus0 and bus2 with different values -> bus0's value is captured.
- Fill to DEPTH with out_ready=0 -> full=1, in_ready=0, and an extra in_valid is not accepted. Then assert out_ready=1 with in_valid=1 -> count stays at DEPTH-1 after the first cycle, and the freed slot is refilled on the next cycle.
- Dispatch with wait_b=1, tag_b=4 while fwd bus0 = {1, 4, 0x1234} in the same cycle -> entry is ready next cycle with out_val_b=0x1234.
- With 3 entries busy, assert flush together with in_valid and out_ready -> count=0 next cycle, out_valid=0, new op not stored.
- RS_AGE_ORDER_EN defined: allocate rob=1 into slot0 and rob=2 into slot1, issue rob=1, allocate rob=3 into slot0, then make rob=2 and rob=3 ready together -> rob=2 issues first. Without the macro -> rob=3 (slot0) issues first.
